// File: rtl/projectfinal_bcd_entry_if.sv
// Keypad-side bundle for the two-digit BCD entry combiner: key strobes in,
// converted number and live digit pair out.
interface projectfinal_bcd_entry_if;
  logic       KEY_VALID;
  logic [3:0] KEY_DIGIT;
  logic       KEY_ENT;
  logic       KEY_CLR;
  logic [6:0] NUM;
  logic       NUM_VALID;
  logic       ERR;
  logic [3:0] D10;
  logic [3:0] D1;
  logic [1:0] CNT;

  modport master (
    output KEY_VALID, KEY_DIGIT, KEY_ENT, KEY_CLR,
    input  NUM, NUM_VALID, ERR, D10, D1, CNT
  );

  modport slave (
    input  KEY_VALID, KEY_DIGIT, KEY_ENT, KEY_CLR,
    output NUM, NUM_VALID, ERR, D10, D1, CNT
  );
endinterface

// File: rtl/projectfinal_bcd_entry.sv
// Two-digit decimal keypad entry: shifts BCD digits into a tens/ones pair and,
// on ENTER, converts the pair to a 7-bit binary value in a one-cycle CONV state.
module projectfinal_bcd_entry #(
  parameter int MAX_VAL = 99
) (
  input  logic                      CLK,
  input  logic                      RST,
  projectfinal_bcd_entry_if.slave   bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO, CONV} state_t;

  localparam logic [31:0] LP_MAX = MAX_VAL;

  state_t     r_state, w_state_n;
  logic [3:0] r_d10, w_d10_n;
  logic [3:0] r_d1, w_d1_n;
  logic [1:0] r_cnt, w_cnt_n;
  logic [6:0] r_num, w_num_n;
  logic       r_nv, w_nv_n;
  logic       r_err, w_err_n;

  logic [6:0] w_res;
  logic       w_in_range;
  logic       w_dig_ok;

  // d10*10 + d1 as d10*8 + d10*2 + d1; max 99 fits 7 bits
  assign w_res      = {r_d10, 3'b000} + {2'b00, r_d10, 1'b0} + {3'b000, r_d1};
  assign w_in_range = ({25'd0, w_res} <= LP_MAX);
  assign w_dig_ok   = (bus.KEY_DIGIT <= 4'd9);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= EMPTY;
      r_d10   <= 4'd0;
      r_d1    <= 4'd0;
      r_cnt   <= 2'd0;
      r_num   <= 7'd0;
      r_nv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_d10   <= w_d10_n;
      r_d1    <= w_d1_n;
      r_cnt   <= w_cnt_n;
      r_num   <= w_num_n;
      r_nv    <= w_nv_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_d10_n   = r_d10;
    w_d1_n    = r_d1;
    w_cnt_n   = r_cnt;
    w_num_n   = r_num;
    w_nv_n    = 1'b0;
    w_err_n   = 1'b0;

    if (bus.KEY_CLR) begin
      // clear wins over everything, including an in-flight conversion
      w_state_n = EMPTY;
      w_d10_n   = 4'd0;
      w_d1_n    = 4'd0;
      w_cnt_n   = 2'd0;
    end else begin
      case (r_state)
        CONV: begin
          if (w_in_range) begin
            w_num_n = w_res;
            w_nv_n  = 1'b1;
          end else begin
            w_err_n = 1'b1;
          end
          w_state_n = EMPTY;
          w_d10_n   = 4'd0;
          w_d1_n    = 4'd0;
          w_cnt_n   = 2'd0;
        end
        default: begin
          if (bus.KEY_ENT) begin
            if (r_state == EMPTY) w_err_n   = 1'b1;
            else                  w_state_n = CONV;
          end else if (bus.KEY_VALID) begin
            if (!w_dig_ok) begin
              w_err_n = 1'b1;
            end else begin
              // D1 is already 0 in EMPTY, so the shift loads D10=0 there
              w_d10_n   = r_d1;
              w_d1_n    = bus.KEY_DIGIT;
              w_cnt_n   = (r_cnt == 2'd2) ? 2'd2 : r_cnt + 2'd1;
              w_state_n = (r_state == EMPTY) ? ONE : TWO;
            end
          end
        end
      endcase
    end
  end

  assign bus.NUM       = r_num;
  assign bus.NUM_VALID = r_nv;
  assign bus.ERR       = r_err;
  assign bus.D10       = r_d10;
  assign bus.D1        = r_d1;
  assign bus.CNT       = r_cnt;

endmodule

// File: tb/tb_projectfinal_bcd_entry.sv
// Directed bench for the BCD entry combiner; two instances (MAX_VAL 99 and 50)
// share stimulus and are checked every cycle against a value-level model.
module tb_projectfinal_bcd_entry;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  projectfinal_bcd_entry_if if0();
  projectfinal_bcd_entry_if if1();

  projectfinal_bcd_entry #(.MAX_VAL(99)) dut0 (.CLK(CLK), .RST(RST), .bus(if0));
  projectfinal_bcd_entry #(.MAX_VAL(50)) dut1 (.CLK(CLK), .RST(RST), .bus(if1));

  int cmp_n = 0;
  int bad_n = 0;

  function automatic void chk(string nm, int got, int want);
    cmp_n++;
    if (got != want) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endfunction

  // model: entry held as a plain decimal value plus digit count
  int m_val[2], m_cnt[2], m_num[2], m_nv[2], m_err[2], m_conv[2];
  int m_max[2] = '{99, 50};

  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      int o_num, o_nv, o_err, o_d10, o_d1, o_cnt;
      if (k == 0) begin
        o_num = int'(if0.NUM); o_nv = int'(if0.NUM_VALID); o_err = int'(if0.ERR);
        o_d10 = int'(if0.D10); o_d1 = int'(if0.D1); o_cnt = int'(if0.CNT);
      end else begin
        o_num = int'(if1.NUM); o_nv = int'(if1.NUM_VALID); o_err = int'(if1.ERR);
        o_d10 = int'(if1.D10); o_d1 = int'(if1.D1); o_cnt = int'(if1.CNT);
      end
      if (RST) begin
        m_val[k] = 0; m_cnt[k] = 0; m_num[k] = 0;
        m_nv[k] = 0; m_err[k] = 0; m_conv[k] = 0;
      end
      chk($sformatf("dut%0d NUM", k), o_num, m_num[k]);
      chk($sformatf("dut%0d NUM_VALID", k), o_nv, m_nv[k]);
      chk($sformatf("dut%0d ERR", k), o_err, m_err[k]);
      chk($sformatf("dut%0d D10", k), o_d10, m_val[k] / 10);
      chk($sformatf("dut%0d D1", k), o_d1, m_val[k] % 10);
      chk($sformatf("dut%0d CNT", k), o_cnt, m_cnt[k]);
      chk($sformatf("dut%0d NV&ERR", k), o_nv & o_err, 0);
      if (!RST) begin
        m_nv[k] = 0; m_err[k] = 0;
        if (if0.KEY_CLR) begin
          m_val[k] = 0; m_cnt[k] = 0; m_conv[k] = 0;
        end else if (m_conv[k] != 0) begin
          if (m_val[k] <= m_max[k]) begin m_num[k] = m_val[k]; m_nv[k] = 1; end
          else m_err[k] = 1;
          m_val[k] = 0; m_cnt[k] = 0; m_conv[k] = 0;
        end else if (if0.KEY_ENT) begin
          if (m_cnt[k] == 0) m_err[k] = 1;
          else m_conv[k] = 1;
        end else if (if0.KEY_VALID) begin
          if (int'(if0.KEY_DIGIT) > 9) m_err[k] = 1;
          else begin
            m_val[k] = (m_val[k] % 10) * 10 + int'(if0.KEY_DIGIT);
            m_cnt[k] = (m_cnt[k] == 2) ? 2 : m_cnt[k] + 1;
          end
        end
      end
    end
  end

  // drive one cycle of keys to both instances; returns 1ns after the sampling edge
  task automatic drv(input logic v, input logic [3:0] d, input logic e, input logic c);
    if0.KEY_VALID = v; if0.KEY_DIGIT = d; if0.KEY_ENT = e; if0.KEY_CLR = c;
    if1.KEY_VALID = v; if1.KEY_DIGIT = d; if1.KEY_ENT = e; if1.KEY_CLR = c;
    @(posedge CLK); #1;
  endtask

  task automatic key(input logic [3:0] d); drv(1'b1, d, 1'b0, 1'b0); endtask
  task automatic ent();  drv(1'b0, 4'd0, 1'b1, 1'b0); endtask
  task automatic idle(); drv(1'b0, 4'd0, 1'b0, 1'b0); endtask

  initial begin
    if0.KEY_VALID = 0; if0.KEY_DIGIT = 0; if0.KEY_ENT = 0; if0.KEY_CLR = 0;
    if1.KEY_VALID = 0; if1.KEY_DIGIT = 0; if1.KEY_ENT = 0; if1.KEY_CLR = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst NUM", int'(if0.NUM), 0);
    chk("rst CNT", int'(if0.CNT), 0);
    RST = 0;
    idle();

    // reset mid-entry
    key(5); key(6);
    chk("pre-rst CNT", int'(if0.CNT), 2);
    chk("pre-rst D10", int'(if0.D10), 5);
    RST = 1; #1;
    chk("async rst CNT", int'(if0.CNT), 0);
    chk("async rst D10", int'(if0.D10), 0);
    chk("async rst D1", int'(if0.D1), 0);
    @(posedge CLK); #1;
    RST = 0;
    key(3); ent();
    chk("3 NV early", int'(if0.NUM_VALID), 0);
    idle();
    chk("3 NUM", int'(if0.NUM), 3);
    chk("3 NV", int'(if0.NUM_VALID), 1);
    idle();
    chk("3 NV drop", int'(if0.NUM_VALID), 0);

    // 42
    key(4); key(2);
    chk("42 D10", int'(if0.D10), 4);
    chk("42 D1", int'(if0.D1), 2);
    ent(); idle();
    chk("42 NUM", int'(if0.NUM), 42);
    chk("42 CNT", int'(if0.CNT), 0);
    idle();

    // three digits keep the last two
    key(1); key(2); key(3);
    chk("123 D10", int'(if0.D10), 2);
    chk("123 CNT", int'(if0.CNT), 2);
    ent(); idle();
    chk("23 NUM", int'(if0.NUM), 23);
    idle();

    // out of range on the MAX_VAL=50 instance
    key(9); key(9); ent(); idle();
    chk("99 NUM dut0", int'(if0.NUM), 99);
    chk("99 ERR dut1", int'(if1.ERR), 1);
    chk("99 NUM dut1", int'(if1.NUM), 23);
    chk("99 CNT dut1", int'(if1.CNT), 0);
    idle();

    key(0); key(0); ent(); idle();
    chk("00 NV", int'(if0.NUM_VALID), 1);
    chk("00 NUM", int'(if0.NUM), 0);
    idle();

    // empty ENTER, illegal digit
    ent();
    chk("empty ent ERR", int'(if0.ERR), 1);
    idle();
    chk("err drop", int'(if0.ERR), 0);
    key(4); key(4'hA);
    chk("bad dig ERR", int'(if0.ERR), 1);
    chk("bad dig D1", int'(if0.D1), 4);
    chk("bad dig CNT", int'(if0.CNT), 1);
    drv(1'b0, 4'd0, 1'b0, 1'b1);

    // CLR beats ENT
    key(1); key(2);
    drv(1'b0, 4'd0, 1'b1, 1'b1);
    idle();
    chk("clr+ent NV", int'(if0.NUM_VALID), 0);
    chk("clr+ent ERR", int'(if0.ERR), 0);

    // ENT beats digit
    key(8);
    drv(1'b1, 4'd7, 1'b1, 1'b0);
    idle();
    chk("8 NUM", int'(if0.NUM), 8);
    idle();

    // CLR aborts CONV
    key(6); key(1); ent();
    drv(1'b0, 4'd0, 1'b0, 1'b1);
    chk("abort NV", int'(if0.NUM_VALID), 0);
    chk("abort NUM", int'(if0.NUM), 8);
    idle();

    // digit during CONV is ignored
    key(6); key(1); ent();
    key(5);
    chk("61 NUM", int'(if0.NUM), 61);
    chk("61 CNT", int'(if0.CNT), 0);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end
endmodule
